// File: rtl/updown_sweep_ctrl.sv
// Bounded triangular sweep sequencer: drives count lo->hi->lo for num_sweeps sweeps under start/busy/done.
// Define SWEEP_DWELL_EN to add a DWELL-cycle hold at each turnaround.
module updown_sweep_ctrl #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned SWEEP_W = 8,
   parameter int unsigned DWELL   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               pause,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [SWEEP_W-1:0] num_sweeps,
   output logic [WIDTH-1:0]   count,
   output logic               dir,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   localparam int unsigned DWELL_W = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_UP    = 3'd1,
      S_DOWN  = 3'd2,
      S_DONE  = 3'd3
`ifdef SWEEP_DWELL_EN
      , S_DWELL = 3'd4
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   count_d;
   logic               dir_d;
   logic               busy_d;
   logic               done_d;
   logic               err_d;
   logic [SWEEP_W-1:0] sweep_d;
   logic [SWEEP_W-1:0] sweep_inc;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [SWEEP_W-1:0] num_q, num_d;

`ifdef SWEEP_DWELL_EN
   logic [DWELL_W-1:0] dwell_q, dwell_d;
`else
   logic unused_dwell;
   assign unused_dwell = ^DWELL_W'(DWELL);
`endif

   assign sweep_inc = SWEEP_W'(sweep_cnt + 1'b1);

   // Next-state and next-output logic; abort outranks pause in every busy state.
   always_comb begin
      state_d = state_q;
      count_d = count;
      dir_d   = dir;
      sweep_d = sweep_cnt;
      lo_d    = lo_q;
      hi_d    = hi_q;
      num_d   = num_q;
      err_d   = 1'b0;
`ifdef SWEEP_DWELL_EN
      dwell_d = dwell_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (lo < hi) begin
                  lo_d    = lo;
                  hi_d    = hi;
                  num_d   = num_sweeps;
                  count_d = lo;
                  dir_d   = 1'b1;
                  sweep_d = '0;
                  state_d = S_UP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_UP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!pause) begin
               if (count != hi_q) begin
                  count_d = WIDTH'(count + 1'b1);
               end else begin
                  dir_d = 1'b0;
`ifdef SWEEP_DWELL_EN
                  dwell_d = DWELL_W'(DWELL - 1);
                  state_d = S_DWELL;
`else
                  count_d = WIDTH'(hi_q - 1'b1);
                  state_d = S_DOWN;
`endif
               end
            end
         end
         S_DOWN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!pause) begin
               if (count != lo_q) begin
                  count_d = WIDTH'(count - 1'b1);
               end else begin
                  sweep_d = sweep_inc;
                  // num_sweeps of zero means run until aborted
                  if ((num_q != '0) && (sweep_inc == num_q)) begin
                     state_d = S_DONE;
                  end else begin
                     dir_d = 1'b1;
`ifdef SWEEP_DWELL_EN
                     dwell_d = DWELL_W'(DWELL - 1);
                     state_d = S_DWELL;
`else
                     count_d = WIDTH'(lo_q + 1'b1);
                     state_d = S_UP;
`endif
                  end
               end
            end
         end
`ifdef SWEEP_DWELL_EN
         S_DWELL: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!pause) begin
               if (dwell_q == '0) begin
                  // dir was already flipped on entry, so it names the leg to resume
                  if (dir) begin
                     count_d = WIDTH'(lo_q + 1'b1);
                     state_d = S_UP;
                  end else begin
                     count_d = WIDTH'(hi_q - 1'b1);
                     state_d = S_DOWN;
                  end
               end else begin
                  dwell_d = DWELL_W'(dwell_q - 1'b1);
               end
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_UP) || (state_d == S_DOWN)
`ifdef SWEEP_DWELL_EN
               || (state_d == S_DWELL)
`endif
               ;
      done_d = (state_d == S_DONE);
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count     <= '0;
         dir       <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         sweep_cnt <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         num_q     <= '0;
`ifdef SWEEP_DWELL_EN
         dwell_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count     <= count_d;
         dir       <= dir_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         sweep_cnt <= sweep_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         num_q     <= num_d;
`ifdef SWEEP_DWELL_EN
         dwell_q   <= dwell_d;
`endif
      end
   end

endmodule
